// File: rtl/ita_output_streamer_pkg.sv
// Shared types and sizing for the ITA output streamer.
package ita_output_streamer_pkg;

    localparam int unsigned N         = 16;
    localparam int unsigned WI        = 8;
    localparam int unsigned BusWidth  = 32;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned CntWidth  = 16;

    localparam int unsigned VecWidth     = N * WI;
    localparam int unsigned BeatsPerVec  = VecWidth / BusWidth;
    localparam int unsigned BeatBytes    = BusWidth / 8;
    localparam int unsigned VecBytes     = VecWidth / 8;
    localparam int unsigned BeatIdxWidth = (BeatsPerVec > 1) ? $clog2(BeatsPerVec) : 1;

    typedef logic [BeatIdxWidth-1:0] beat_idx_t;

    typedef enum logic [1:0] {
        OsIdle,
        OsRun,
        OsDone
    } out_stream_state_e;

    typedef struct packed {
        logic [AddrWidth-1:0] base_addr;
        logic [AddrWidth-1:0] row_stride;
        logic [CntWidth-1:0]  vecs_per_row;
        logic [CntWidth-1:0]  num_vecs;
    } out_stream_cfg_t;

endpackage

// File: rtl/ita_output_addr_gen.sv
// Beat/column/row address walker for the output streamer.
// Address = row_base + col*VecBytes + beat*BeatBytes, all modulo 2^AddrWidth.
module ita_output_addr_gen
    import ita_output_streamer_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  out_stream_cfg_t      cfg_i,
    input  logic                 advance_i,
    output logic [AddrWidth-1:0] addr_o,
    output beat_idx_t            beat_o,
    output logic                 last_beat_o,
    output logic                 last_vec_o
);

    out_stream_cfg_t      cfg_q;
    logic [AddrWidth-1:0] row_base_q;
    logic [CntWidth-1:0]  col_q;
    logic [CntWidth-1:0]  vec_q;
    beat_idx_t            beat_q;

    assign beat_o      = beat_q;
    assign last_beat_o = (beat_q == beat_idx_t'(BeatsPerVec - 1));
    assign last_vec_o  = (vec_q == cfg_q.num_vecs - CntWidth'(1));
    assign addr_o      = row_base_q
                       + AddrWidth'(col_q) * AddrWidth'(VecBytes)
                       + AddrWidth'(beat_q) * AddrWidth'(BeatBytes);

    // Counter walk: beats within a vector, then columns, then rows.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_q      <= '0;
            row_base_q <= '0;
            col_q      <= '0;
            vec_q      <= '0;
            beat_q     <= '0;
        end else if (load_i) begin
            cfg_q      <= cfg_i;
            row_base_q <= cfg_i.base_addr;
            col_q      <= '0;
            vec_q      <= '0;
            beat_q     <= '0;
        end else if (advance_i) begin
            if (last_beat_o) begin
                beat_q <= '0;
                vec_q  <= vec_q + CntWidth'(1);
                if (col_q == cfg_q.vecs_per_row - CntWidth'(1)) begin
                    col_q      <= '0;
                    row_base_q <= row_base_q + cfg_q.row_stride;
                end else begin
                    col_q <= col_q + CntWidth'(1);
                end
            end else begin
                beat_q <= beat_q + beat_idx_t'(1);
            end
        end
    end

endmodule

// File: rtl/ita_output_streamer.sv
// Serializes requantized ITA output vectors into bus-width write beats
// laid out row-major in L1.
//
// state  | meaning
// OsIdle | waiting for start_i; cfg sampled on accept
// OsRun  | accepting vectors and issuing write beats
// OsDone | one-cycle completion pulse, then back to idle
module ita_output_streamer
    import ita_output_streamer_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [AddrWidth-1:0]  base_addr_i,
    input  logic [AddrWidth-1:0]  row_stride_i,
    input  logic [CntWidth-1:0]   vecs_per_row_i,
    input  logic [CntWidth-1:0]   num_vecs_i,
    output logic                  busy_o,
    output logic                  done_o,
    input  logic                  inp_valid_i,
    output logic                  inp_ready_o,
    input  logic [VecWidth-1:0]   inp_i,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic [AddrWidth-1:0]  mem_addr_o,
    output logic [BusWidth-1:0]   mem_wdata_o,
    output logic [BusWidth/8-1:0] mem_be_o
);

    out_stream_state_e                   state_q, state_d;
    logic [BeatsPerVec-1:0][BusWidth-1:0] vec_buf_q;
    logic                                full_q;
    logic [CntWidth-1:0]                 acc_q;
    logic [CntWidth-1:0]                 num_vecs_q;
    out_stream_cfg_t                     cfg_in;
    beat_idx_t                           beat;
    logic                                last_beat;
    logic                                last_vec;
    logic                                start_acc;
    logic                                beat_done;
    logic                                vec_done;
    logic                                inp_fire;

    assign cfg_in = '{base_addr:    base_addr_i,
                      row_stride:   row_stride_i,
                      vecs_per_row: vecs_per_row_i,
                      num_vecs:     num_vecs_i};

    assign beat_done   = full_q && mem_gnt_i;
    assign vec_done    = beat_done && last_beat;
    assign inp_fire    = inp_valid_i && inp_ready_o;
    assign mem_req_o   = full_q;
    assign mem_wdata_o = vec_buf_q[beat];
    assign mem_be_o    = '1;

    ita_output_addr_gen i_addr_gen (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (start_acc),
        .cfg_i       (cfg_in),
        .advance_i   (beat_done),
        .addr_o      (mem_addr_o),
        .beat_o      (beat),
        .last_beat_o (last_beat),
        .last_vec_o  (last_vec)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= OsIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, status outputs and input-side ready.
    // Ready looks at the grant so a new vector can load on the last beat.
    always_comb begin
        state_d     = state_q;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        inp_ready_o = 1'b0;
        start_acc   = 1'b0;
        case (state_q)
            OsIdle: begin
                if (start_i) begin
                    start_acc = 1'b1;
                    state_d   = (num_vecs_i == '0) ? OsDone : OsRun;
                end
            end
            OsRun: begin
                busy_o      = 1'b1;
                inp_ready_o = (acc_q < num_vecs_q) && (!full_q || vec_done);
                if (vec_done && last_vec) begin
                    state_d = OsDone;
                end
            end
            OsDone: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = OsIdle;
            end
            default: state_d = OsIdle;
        endcase
    end

    // Vector buffer, full flag and accepted-vector count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vec_buf_q  <= '0;
            full_q     <= 1'b0;
            acc_q      <= '0;
            num_vecs_q <= '0;
        end else begin
            if (start_acc) begin
                acc_q      <= '0;
                num_vecs_q <= num_vecs_i;
            end
            if (inp_fire) begin
                vec_buf_q <= inp_i;
                full_q    <= 1'b1;
                acc_q     <= acc_q + CntWidth'(1);
            end else if (vec_done) begin
                full_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ita_output_streamer.sv
// Scoreboard bench for ita_output_streamer.
module tb_ita_output_streamer;
    import ita_output_streamer_pkg::*;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [31:0]   base_addr_i = '0;
    logic [31:0]   row_stride_i = '0;
    logic [15:0]   vecs_per_row_i = '0;
    logic [15:0]   num_vecs_i = '0;
    logic          busy_o, done_o;
    logic          inp_valid_i = 1'b0;
    logic          inp_ready_o;
    logic [127:0]  inp_i = '0;
    logic          mem_req_o;
    logic          mem_gnt_i = 1'b0;
    logic [31:0]   mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [3:0]    mem_be_o;

    ita_output_streamer dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .base_addr_i    (base_addr_i),
        .row_stride_i   (row_stride_i),
        .vecs_per_row_i (vecs_per_row_i),
        .num_vecs_i     (num_vecs_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .inp_valid_i    (inp_valid_i),
        .inp_ready_o    (inp_ready_o),
        .inp_i          (inp_i),
        .mem_req_o      (mem_req_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_be_o       (mem_be_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    beat_t sb[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    int    gnt_mode = 0;      // 0: gnt low, 1: gnt high, 2: random 50%
    int    gcount = 0;
    int    gnt_cyc[0:1023];
    bit    tp_check = 1'b0;
    int    tp_base = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Grant driver, applied after the main process has updated its inputs.
    always begin
        @(posedge clk_i);
        #2;
        case (gnt_mode)
            0: mem_gnt_i = 1'b0;
            1: mem_gnt_i = 1'b1;
            default: mem_gnt_i = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: pops the scoreboard on each granted beat and checks hold stability.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_data = '0;
    always @(negedge clk_i) begin
        beat_t e;
        if (!rst_i && mem_req_o) begin
            if (prev_stall) begin
                tests++;
                if (mem_addr_o !== prev_addr || mem_wdata_o !== prev_data) begin
                    fails++;
                    $display("FAIL hold: addr %h data %h, required addr %h data %h",
                             mem_addr_o, mem_wdata_o, prev_addr, prev_data);
                end
            end
            if (mem_gnt_i) begin
                if (gcount < 1024) gnt_cyc[gcount] = cyc;
                if (tp_check && ((gcount - tp_base) % 4 == 3) && ((gcount - tp_base) < 31)) begin
                    tests++;
                    if (inp_ready_o !== 1'b1) begin
                        fails++;
                        $display("FAIL tp_ready: grant %0d ready %b, required 1", gcount - tp_base, inp_ready_o);
                    end
                end
                gcount++;
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL beat: unexpected beat addr %h data %h, required none", mem_addr_o, mem_wdata_o);
                end else begin
                    e = sb.pop_front();
                    if (mem_addr_o !== e.addr || mem_wdata_o !== e.data) begin
                        fails++;
                        $display("FAIL beat: addr %h data %h, required addr %h data %h",
                                 mem_addr_o, mem_wdata_o, e.addr, e.data);
                    end
                end
                tests++;
                if (mem_be_o !== 4'hF) begin
                    fails++;
                    $display("FAIL be: %h, required f", mem_be_o);
                end
            end
        end
        prev_stall = !rst_i && mem_req_o && !mem_gnt_i;
        prev_addr  = mem_addr_o;
        prev_data  = mem_wdata_o;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic start_job(input logic [31:0] base, input logic [31:0] stride,
                             input logic [15:0] vpr, input logic [15:0] nv);
        base_addr_i    = base;
        row_stride_i   = stride;
        vecs_per_row_i = vpr;
        num_vecs_i     = nv;
        start_i        = 1'b1;
        tick();
        start_i        = 1'b0;
    endtask

    // Lane k = seed+k; pushes the four expected beats before offering the vector.
    task automatic send_vec(input logic [31:0] vbase, input logic [7:0] seed);
        logic [127:0] v;
        beat_t        b;
        int           waited;
        for (int k = 0; k < 16; k++) v[k*8 +: 8] = seed + 8'(k);
        for (int i = 0; i < 4; i++) begin
            b.addr = vbase + 32'(4 * i);
            b.data = v[i*32 +: 32];
            sb.push_back(b);
        end
        inp_valid_i = 1'b1;
        inp_i       = v;
        waited      = 0;
        forever begin
            @(negedge clk_i);
            if (inp_ready_o) break;
            waited++;
            if (waited > 200) begin
                tests++;
                fails++;
                $display("FAIL handshake: no ready after %0d cycles, required ready", waited);
                break;
            end
        end
        tick();
        inp_valid_i = 1'b0;
    endtask

    task automatic wait_done(output int dcyc);
        int w;
        w    = 0;
        dcyc = -1;
        forever begin
            @(negedge clk_i);
            if (done_o) begin
                dcyc = cyc;
                break;
            end
            w++;
            if (w > 500) begin
                tests++;
                fails++;
                $display("FAIL done_timeout: done_o 0 after %0d cycles, required 1", w);
                break;
            end
        end
        check("sb_empty_at_done", 32'(sb.size()), 32'd0);
        @(negedge clk_i);
        check("done_one_cycle", {31'd0, done_o}, 32'd0);
        check("idle_after_done", {31'd0, busy_o}, 32'd0);
    endtask

    task automatic run_job(input logic [31:0] base, input logic [31:0] stride,
                           input logic [15:0] vpr, input logic [15:0] nv,
                           input logic [7:0] seed, output int dcyc);
        logic [31:0] vb;
        start_job(base, stride, vpr, nv);
        for (int v = 0; v < int'(nv); v++) begin
            vb = base + 32'(v / int'(vpr)) * stride + 32'((v % int'(vpr)) * 16);
            send_vec(vb, seed + 8'(16 * v));
        end
        wait_done(dcyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcyc, g0, s;

        // Reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_busy",  {31'd0, busy_o},      32'd0);
        check("rst_done",  {31'd0, done_o},      32'd0);
        check("rst_req",   {31'd0, mem_req_o},   32'd0);
        check("rst_ready", {31'd0, inp_ready_o}, 32'd0);
        check("rst_addr",  mem_addr_o,           32'd0);
        check("rst_wdata", mem_wdata_o,          32'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Single vector, lanes 0x00..0x0F, base 0x1000, gnt high
        gnt_mode = 1;
        run_job(32'h1000, 32'h0, 16'd1, 16'd1, 8'h00, dcyc);
        check("single_done_latency", 32'(dcyc), 32'(gnt_cyc[gcount-1] + 1));

        // Row wrap: 2 vectors per row, stride 0x100
        start_job(32'h1000, 32'h100, 16'd2, 16'd4);
        send_vec(32'h1000, 8'h10);
        send_vec(32'h1010, 8'h20);
        send_vec(32'h1100, 8'h30);
        send_vec(32'h1110, 8'h40);
        wait_done(dcyc);

        // Random backpressure, 64 bytes
        gnt_mode = 2;
        g0 = gcount;
        run_job(32'h2000, 32'h40, 16'd4, 16'd4, 8'h50, dcyc);
        check("bp_grants", 32'(gcount - g0), 32'd16);

        // Throughput: 8 vectors, continuous valid and gnt
        gnt_mode = 1;
        @(negedge clk_i);
        g0       = gcount;
        tp_base  = gcount;
        tp_check = 1'b1;
        run_job(32'h4000, 32'h80, 16'd8, 16'd8, 8'h60, dcyc);
        tp_check = 1'b0;
        check("tp_grants", 32'(gcount - g0), 32'd32);
        if (gcount - g0 == 32)
            check("tp_span", 32'(gnt_cyc[g0+31] - gnt_cyc[g0]), 32'd31);

        // Address wrap modulo 2^32
        run_job(32'hFFFF_FFF8, 32'h0, 16'd1, 16'd1, 8'hA0, dcyc);

        // num_vecs = 0, with valid held high in Idle
        @(posedge clk_i);
        #1;
        inp_valid_i    = 1'b1;
        inp_i          = {16{8'hEE}};
        base_addr_i    = 32'h5000;
        num_vecs_i     = 16'd0;
        vecs_per_row_i = 16'd1;
        start_i        = 1'b1;
        @(negedge clk_i);
        check("idle_ready", {31'd0, inp_ready_o}, 32'd0);
        s = cyc;
        tick();
        start_i = 1'b0;
        @(negedge clk_i);
        check("zero_done",       {31'd0, done_o},      32'd1);
        check("zero_done_cycle", 32'(cyc),             32'(s + 1));
        check("zero_req",        {31'd0, mem_req_o},   32'd0);
        check("zero_ready",      {31'd0, inp_ready_o}, 32'd0);
        @(negedge clk_i);
        check("zero_done_off",   {31'd0, done_o},      32'd0);
        check("zero_ready2",     {31'd0, inp_ready_o}, 32'd0);
        @(posedge clk_i);
        #1 inp_valid_i = 1'b0;

        // Reset at beat 2 of a vector
        gnt_mode = 0;
        start_job(32'h3000, 32'h100, 16'd1, 16'd1);
        send_vec(32'h3000, 8'h80);
        gnt_mode = 1;
        tick();
        tick();
        gnt_mode = 0;
        rst_i    = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        check("mid_rst_req",   {31'd0, mem_req_o},   32'd0);
        check("mid_rst_busy",  {31'd0, busy_o},      32'd0);
        check("mid_rst_ready", {31'd0, inp_ready_o}, 32'd0);
        check("mid_rst_left",  32'(sb.size()),       32'd2);
        sb.delete();
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        gnt_mode = 1;
        run_job(32'h3000, 32'h100, 16'd1, 16'd1, 8'h90, dcyc);

        repeat (2) @(posedge clk_i);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
